student_prescaled_counter: RTL

Parametrised prescaled up/down/load counter, the successor to the fixed divide-by-2, 8-bit clear-only counter used in the student circuit exercises. A prescaler produces a one-cycle enable every DIV clock cycles, and the counter steps on that enable. There is no derived clock: everything runs on `clk`. The block sits between the exercise stimulus (`cct_input`, mode controls) and the result bus `cct_output`, and flags overflow/underflow for the grading logic.

---
 rtl/student_counter_pkg.sv | 13 +
 rtl/student_tick_gen.sv | 24 ++
 rtl/student_prescaled_counter.sv | 62 ++++++
 3 files changed

// File: rtl/student_counter_pkg.sv
// student_counter_pkg: shared mode encoding and limits for the prescaled counter
// Contents:
//   cnt_mode_t  counter operation selected by the mode input
//   MAX_WIDTH   widest supported counter
package student_counter_pkg;
   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DOWN = 2'b10,
      MODE_LOAD = 2'b11
   } cnt_mode_t;
   localparam int MAX_WIDTH = 32;
endpackage

// File: rtl/student_tick_gen.sv
// student_tick_gen: prescaler producing a one-cycle enable every DIV clocks
// Ports:
//   clk         system clock
//   clear_n     asynchronous active-low reset
//   sync_clear  synchronous prescaler clear
//   tick        high while the prescaler sits at DIV-1 (constantly high for DIV=1)
module student_tick_gen
   import student_counter_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic clear_n,
   input  logic sync_clear,
   output logic tick
);
   localparam int PRE_W = $clog2(DIV > 1 ? DIV : 2);
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   assign tick = pre_cnt_q == PRE_W'(DIV - 1);
   always_comb pre_cnt_d = (sync_clear || tick) ? '0 : pre_cnt_q + 1'b1;
   always_ff @(posedge clk or negedge clear_n)
      if (!clear_n) pre_cnt_q <= '0;
      else          pre_cnt_q <= pre_cnt_d;
endmodule

// File: rtl/student_prescaled_counter.sv
// student_prescaled_counter: prescaled up/down/load counter with overflow/underflow pulse
// Ports:
//   clk         system clock
//   clear_n     asynchronous active-low reset
//   sync_clear  synchronous clear of counter, prescaler and terminal
//   mode        00 hold, 01 up, 10 down, 11 load
//   cct_input   load value
//   cct_output  registered count
//   tick        prescaler enable
//   terminal    one-cycle pulse on a step attempted at the count limit
// Build option: COUNTER_SATURATE_EN makes the count stick at its limits instead of wrapping.
module student_prescaled_counter
   import student_counter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 2
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             sync_clear,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] cct_input,
   output logic [WIDTH-1:0] cct_output,
   output logic             tick,
   output logic             terminal
);
`ifdef COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   cnt_mode_t m;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic term_q, term_d, step, at_lim;
   assign m = cnt_mode_t'(mode);
   student_tick_gen #(.DIV(DIV)) u_tick (
      .clk       (clk),
      .clear_n   (clear_n),
      .sync_clear(sync_clear),
      .tick      (tick)
   );
   always_comb begin
      step   = tick && (m == MODE_UP || m == MODE_DOWN);
      // limit depends on direction: all-ones going up, zero going down
      at_lim = (m == MODE_UP) ? &cnt_q : cnt_q == '0;
      cnt_d  = sync_clear ? '0 :
               m == MODE_LOAD ? cct_input :
               (!step || (SAT && at_lim)) ? cnt_q :
               m == MODE_UP ? cnt_q + 1'b1 : cnt_q - 1'b1;
      term_d = !sync_clear && step && at_lim;
   end
   always_ff @(posedge clk or negedge clear_n)
      if (!clear_n) begin
         cnt_q  <= '0;
         term_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         term_q <= term_d;
      end
   assign cct_output = cnt_q;
   assign terminal   = term_q;
endmodule
